// File: rtl/lmem_4rp_1wp_seq.sv
// lmem_4rp_1wp_seq
//   Four-read / one-write local memory built on a storage array that has
//   only two read ports. Port A is shared with the write port and port B is
//   read-only. A request for four words is served in two read beats
//   (addr0/addr1, then addr2/addr3). All four results are then published
//   together with a one-cycle q_valid pulse.
//
// Ports
//   clk                 single clock, rising edge
//   rst                 synchronous, active-high reset (RAM contents kept)
//   we/waddr/wdata      write port, honoured in every state
//   rd_valid/rd_ready   request handshake; rd_ready is high only in IDLE
//   raddr_0..raddr_3    read addresses, latched at acceptance
//   q_0..q_3            registered read data, stable between result loads
//   q_valid             one-cycle pulse when q_0..q_3 hold a new result
module lmem_4rp_1wp_seq #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] raddr_0,
  input  logic [ADDR_WIDTH-1:0] raddr_1,
  input  logic [ADDR_WIDTH-1:0] raddr_2,
  input  logic [ADDR_WIDTH-1:0] raddr_3,
  output logic [DATA_WIDTH-1:0] q_0,
  output logic [DATA_WIDTH-1:0] q_1,
  output logic [DATA_WIDTH-1:0] q_2,
  output logic [DATA_WIDTH-1:0] q_3,
  output logic                  q_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RD01, RD23, CAP} state_t;

  state_t state;

  // Storage. Not reset: contents survive rst.
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  // Request addresses, captured once at acceptance so that the inputs
  // may change freely while the request is in flight.
  logic [3:0][ADDR_WIDTH-1:0] addr_lat;

  // Port A / port B read registers (staging) and the first-beat result
  // parked until all four words are available.
  logic [DATA_WIDTH-1:0] stg_a, stg_b;
  logic [DATA_WIDTH-1:0] hold_0, hold_1;

  // A write occupies port A, so no read beat may issue in that cycle.
  logic port_a_free;
  assign port_a_free = !we;

  assign rd_ready = (state == IDLE);

  // Write port: active in every state, including while rst is high.
  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

  // Sequencer. The read beats sample ram before this edge's write lands,
  // so a write in the acceptance cycle is visible to the first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_lat <= '0;
      stg_a    <= '0;
      stg_b    <= '0;
      hold_0   <= '0;
      hold_1   <= '0;
      q_0      <= '0;
      q_1      <= '0;
      q_2      <= '0;
      q_3      <= '0;
      q_valid  <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_valid) begin
            addr_lat <= {raddr_3, raddr_2, raddr_1, raddr_0};
            state    <= RD01;
          end
        end
        RD01: begin
          // Stall while the write owns port A.
          if (port_a_free) begin
            stg_a <= ram[addr_lat[0]];
            stg_b <= ram[addr_lat[1]];
            state <= RD23;
          end
        end
        RD23: begin
          if (port_a_free) begin
            hold_0 <= stg_a;
            hold_1 <= stg_b;
            stg_a  <= ram[addr_lat[2]];
            stg_b  <= ram[addr_lat[3]];
            state  <= CAP;
          end
        end
        CAP: begin
          // Publish all four words at once so consumers never see a mix
          // of old and new results.
          q_0     <= hold_0;
          q_1     <= hold_1;
          q_2     <= stg_a;
          q_3     <= stg_b;
          q_valid <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lmem_4rp_1wp_seq.sv
// Randomized + directed bench for lmem_4rp_1wp_seq. A reference model
// tracks memory contents and request progress; completed results are
// queued and a negedge monitor checks them whenever q_valid is seen.
module tb_lmem_4rp_1wp_seq;
  localparam int DW = 18;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] raddr_0 = '0, raddr_1 = '0, raddr_2 = '0, raddr_3 = '0;
  logic [DW-1:0] q_0, q_1, q_2, q_3;
  logic          q_valid;

  lmem_4rp_1wp_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .raddr_0(raddr_0), .raddr_1(raddr_1), .raddr_2(raddr_2), .raddr_3(raddr_3),
    .q_0(q_0), .q_1(q_1), .q_2(q_2), .q_3(q_3), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected completion", nm);
  endtask

  // ---------------- reference model ----------------
  // A request reads words 0/1 on the first write-free edge after
  // acceptance, words 2/3 on the next write-free edge, and the result
  // appears one edge later. Reset drops anything in flight.
  logic [DW-1:0]         mm [2**AW];
  logic [3:0][AW-1:0]    ma;
  logic [3:0][DW-1:0]    md;
  logic [3:0][DW-1:0]    expq [$];
  bit                    busy = 0, m_qv = 0, m_rst = 0, started = 0;
  int                    ph = 0;

  always @(posedge clk) begin
    started = 1;
    m_qv    = 0;
    m_rst   = 0;
    if (rst) begin
      busy  = 0;
      m_rst = 1;
      expq.delete();
    end else if (busy) begin
      if (ph == 2) begin
        expq.push_back(md);
        m_qv = 1;
        busy = 0;
      end else if (!we) begin
        md[2*ph]   = mm[ma[2*ph]];
        md[2*ph+1] = mm[ma[2*ph+1]];
        ph++;
      end
    end else if (rd_valid) begin
      ma   = {raddr_3, raddr_2, raddr_1, raddr_0};
      busy = 1;
      ph   = 0;
    end
    if (we) mm[waddr] = wdata;
  end

  // ---------------- monitor ----------------
  logic [3:0][DW-1:0] held = '0;

  always @(negedge clk) begin
    if (started) begin
      if (m_rst) held = '0;
      chk("q_valid", 32'(q_valid), 32'(m_qv));
      if (q_valid) begin
        if (expq.size() == 0) fail_now("unexpected_q_valid");
        else held = expq.pop_front();
      end
      chk("q_0", 32'(q_0), 32'(held[0]));
      chk("q_1", 32'(q_1), 32'(held[1]));
      chk("q_2", 32'(q_2), 32'(held[2]));
      chk("q_3", 32'(q_3), 32'(held[3]));
      chk("rd_ready", 32'(rd_ready), 32'(!busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    we = 1'b1; waddr = AW'(a); wdata = DW'(d);
    tick();
    we = 1'b0;
  endtask

  // While the DUT is busy, keep rd_valid high with junk addresses; they
  // must be ignored. The real addresses go out in the accepting cycle.
  task automatic issue(input int a0, input int a1, input int a2, input int a3);
    int t = 0;
    while (!rd_ready && t < 60) begin
      rd_valid = 1'b1;
      raddr_0 = AW'($urandom); raddr_1 = AW'($urandom);
      raddr_2 = AW'($urandom); raddr_3 = AW'($urandom);
      tick();
      t++;
    end
    if (!rd_ready) fail_now("issue_wait");
    rd_valid = 1'b1;
    raddr_0 = AW'(a0); raddr_1 = AW'(a1); raddr_2 = AW'(a2); raddr_3 = AW'(a3);
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!rd_ready && t < 60) begin
      tick();
      t++;
    end
    if (!rd_ready) fail_now("idle_wait");
    tick();
  endtask

  initial begin
    // Reset, with a write that must land despite rst.
    we = 1'b1; waddr = 8'd7; wdata = 18'h155;
    tick();
    we = 1'b0;
    tick();
    rst = 1'b0;
    issue(7, 7, 7, 7);
    wait_idle();

    for (int i = 0; i < 2**AW; i++) wr(i, int'($urandom));

    // Basic four-word read.
    wr(1, 'h11); wr(2, 'h22); wr(3, 'h33); wr(4, 'h44);
    issue(1, 2, 3, 4);
    wait_idle();

    // Two-cycle stall while in the first read beat.
    issue(1, 2, 3, 4);
    wr(9, 'h3FF);
    wr(9, 'h3FF);
    wait_idle();
    issue(9, 2, 9, 4);
    wait_idle();

    // Back-to-back requests with rd_valid held.
    issue(4, 3, 2, 1);
    issue(1, 1, 1, 1);
    wait_idle();

    // Write in the acceptance cycle is visible to the read.
    we = 1'b1; waddr = 8'd5; wdata = 18'h2A;
    rd_valid = 1'b1;
    raddr_0 = 8'd5; raddr_1 = 8'd6; raddr_2 = 8'd5; raddr_3 = 8'd8;
    tick();
    we = 1'b0; rd_valid = 1'b0;
    wait_idle();

    // Reset while in the second read beat.
    issue(1, 2, 3, 4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    issue(1, 1, 1, 1);
    wait_idle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      we       = ($urandom_range(0, 3) == 0);
      waddr    = AW'($urandom_range(0, 15));
      wdata    = DW'($urandom);
      rd_valid = $urandom_range(0, 1) == 1;
      raddr_0  = AW'($urandom_range(0, 15));
      raddr_1  = AW'($urandom_range(0, 15));
      raddr_2  = AW'($urandom_range(0, 15));
      raddr_3  = AW'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end
    we = 1'b0; rd_valid = 1'b0; rst = 1'b0;
    wait_idle();
    repeat (3) tick();

    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
